map_table: RTL

- Register alias table for the two-wide dispatch stage.
- Sits directly upstream of the reorder buffer and the reservation stations.
- Per architectural register, records which ROB tag will produce its value and whether that value is already complete in the ROB.
- At dispatch, translates source registers into tags for the RS. Records new destination tags from the ROB, marks them ready on CDB broadcast, and frees them on retirement or mispredict flush.

---
 rtl/map_table.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/map_table.sv
// rtl/map_table.sv - register alias table for the two-wide dispatch stage
// Optional same-cycle CDB ready bypass on lookups: MAP_TABLE_CDB_BYPASS_EN
module map_table #(
   parameter int NUM_REGS  = 32,
   parameter int TAG_W     = 8,
   parameter int ROB_IDX_W = 5,
   localparam int REG_W    = $clog2(NUM_REGS)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush_in,
   input  logic             inst1_valid_in,
   input  logic [REG_W-1:0] inst1_rega_in,
   input  logic [REG_W-1:0] inst1_regb_in,
   input  logic [REG_W-1:0] inst1_dest_in,
   input  logic [TAG_W-1:0] inst1_tag_in,
   input  logic             inst2_valid_in,
   input  logic [REG_W-1:0] inst2_rega_in,
   input  logic [REG_W-1:0] inst2_regb_in,
   input  logic [REG_W-1:0] inst2_dest_in,
   input  logic [TAG_W-1:0] inst2_tag_in,
   input  logic [TAG_W-1:0] cdb1_tag_in,
   input  logic [TAG_W-1:0] cdb2_tag_in,
   input  logic [REG_W-1:0] retire1_dest_in,
   input  logic [TAG_W-1:0] retire1_tag_in,
   input  logic [REG_W-1:0] retire2_dest_in,
   input  logic [TAG_W-1:0] retire2_tag_in,
   output logic [TAG_W-1:0] inst1_rega_tag_out,
   output logic [TAG_W-1:0] inst1_regb_tag_out,
   output logic [TAG_W-1:0] inst2_rega_tag_out,
   output logic [TAG_W-1:0] inst2_regb_tag_out
);

   localparam logic [TAG_W-1:0] NO_TAG = {TAG_W{1'b1}};
   localparam int PAD_W = TAG_W - 1 - ROB_IDX_W;

`ifdef MAP_TABLE_CDB_BYPASS_EN
   localparam logic BYPASS = 1'b1;
`else
   localparam logic BYPASS = 1'b0;
`endif

   logic [NUM_REGS-1:0]  valid_q, valid_d;
   logic [NUM_REGS-1:0]  ready_q, ready_d;
   logic [ROB_IDX_W-1:0] idx_q [NUM_REGS];
   logic [ROB_IDX_W-1:0] idx_d [NUM_REGS];

   logic disp1_en, disp2_en, dep_en;
   logic [TAG_W-1:0] dep_tag;
   logic [TAG_W-1:0] rd1a, rd1b, rd2a, rd2b;

   function automatic logic cdb_hit(
      input logic [ROB_IDX_W-1:0] idx,
      input logic [TAG_W-1:0]     c1,
      input logic [TAG_W-1:0]     c2
   );
      return ((c1 != NO_TAG) && (c1[ROB_IDX_W-1:0] == idx)) ||
             ((c2 != NO_TAG) && (c2[ROB_IDX_W-1:0] == idx));
   endfunction

   // Only the mapping that the retiring instruction created may be cleared.
   function automatic logic retire_hit(
      input logic [REG_W-1:0]     entry,
      input logic                 v,
      input logic [ROB_IDX_W-1:0] idx,
      input logic [REG_W-1:0]     rdest,
      input logic [TAG_W-1:0]     rtag
   );
      return v && (rdest == entry) && (rdest != '0) && (rtag != NO_TAG) &&
             (idx == rtag[ROB_IDX_W-1:0]);
   endfunction

   function automatic logic [TAG_W-1:0] read_entry(
      input logic [REG_W-1:0]     src,
      input logic                 v,
      input logic                 rdy,
      input logic [ROB_IDX_W-1:0] idx,
      input logic                 byp
   );
      if ((src == '0) || !v) begin
         return NO_TAG;
      end
      return {rdy | byp, {PAD_W{1'b0}}, idx};
   endfunction

   always_comb begin
      disp1_en = inst1_valid_in && (inst1_dest_in != '0) && (inst1_tag_in != NO_TAG);
      disp2_en = inst2_valid_in && (inst2_dest_in != '0) && (inst2_tag_in != NO_TAG);
      dep_en   = disp1_en;
      dep_tag  = {1'b0, {PAD_W{1'b0}}, inst1_tag_in[ROB_IDX_W-1:0]};
   end

   always_comb begin
      valid_d = valid_q;
      ready_d = ready_q;
      idx_d   = idx_q;
      if (flush_in) begin
         valid_d = '0;
         ready_d = '0;
      end else begin
         for (int r = 1; r < NUM_REGS; r++) begin
            if (valid_q[r] && cdb_hit(idx_q[r], cdb1_tag_in, cdb2_tag_in)) begin
               ready_d[r] = 1'b1;
            end
            if (retire_hit(REG_W'(r), valid_q[r], idx_q[r], retire1_dest_in, retire1_tag_in) ||
                retire_hit(REG_W'(r), valid_q[r], idx_q[r], retire2_dest_in, retire2_tag_in)) begin
               valid_d[r] = 1'b0;
               ready_d[r] = 1'b0;
            end
            // Slot 2 is younger, so it owns the final mapping on a shared dest.
            if (disp2_en && (inst2_dest_in == REG_W'(r))) begin
               valid_d[r] = 1'b1;
               ready_d[r] = 1'b0;
               idx_d[r]   = inst2_tag_in[ROB_IDX_W-1:0];
            end else if (disp1_en && (inst1_dest_in == REG_W'(r))) begin
               valid_d[r] = 1'b1;
               ready_d[r] = 1'b0;
               idx_d[r]   = inst1_tag_in[ROB_IDX_W-1:0];
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         ready_q <= '0;
         for (int r = 0; r < NUM_REGS; r++) begin
            idx_q[r] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         ready_q <= ready_d;
         for (int r = 0; r < NUM_REGS; r++) begin
            idx_q[r] <= idx_d[r];
         end
      end
   end

   always_comb begin
      rd1a = read_entry(inst1_rega_in, valid_q[inst1_rega_in], ready_q[inst1_rega_in],
                        idx_q[inst1_rega_in],
                        BYPASS & cdb_hit(idx_q[inst1_rega_in], cdb1_tag_in, cdb2_tag_in));
      rd1b = read_entry(inst1_regb_in, valid_q[inst1_regb_in], ready_q[inst1_regb_in],
                        idx_q[inst1_regb_in],
                        BYPASS & cdb_hit(idx_q[inst1_regb_in], cdb1_tag_in, cdb2_tag_in));
      rd2a = read_entry(inst2_rega_in, valid_q[inst2_rega_in], ready_q[inst2_rega_in],
                        idx_q[inst2_rega_in],
                        BYPASS & cdb_hit(idx_q[inst2_rega_in], cdb1_tag_in, cdb2_tag_in));
      rd2b = read_entry(inst2_regb_in, valid_q[inst2_regb_in], ready_q[inst2_regb_in],
                        idx_q[inst2_regb_in],
                        BYPASS & cdb_hit(idx_q[inst2_regb_in], cdb1_tag_in, cdb2_tag_in));
   end

   // Slot 2 sources produced by slot 1 in the same group always wait on slot 1's tag.
   assign inst1_rega_tag_out = rd1a;
   assign inst1_regb_tag_out = rd1b;
   assign inst2_rega_tag_out = (dep_en && (inst2_rega_in == inst1_dest_in)) ? dep_tag : rd2a;
   assign inst2_regb_tag_out = (dep_en && (inst2_regb_in == inst1_dest_in)) ? dep_tag : rd2b;

endmodule
